// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: state encoding, default vectors, step size.
package pc_gen_pkg;

  localparam logic        S_RUN        = 1'b0;
  localparam logic        S_PEND       = 1'b1;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/pc_pend_reg.sv
// Pending-redirect holder: latches a redirect seen during a stall and tracks the RUN/PEND state.
module pc_pend_reg
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0] pend_target,
  output logic             pending
);

  logic             state;
  logic             state_nxt;
  logic [WIDTH-1:0] target_nxt;

  // Ternaries keep an X on stall visible instead of resolving it as false.
  always_comb begin
    state_nxt  = state;
    target_nxt = pend_target;
    state_nxt  = exc_req ? S_RUN
               : stall   ? (redir_valid ? S_PEND : state)
               :           S_RUN;
    target_nxt = exc_req               ? '0
               : (stall & redir_valid) ? redir_target
               :                         pend_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RUN;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= target_nxt;
    end
  end

  assign pending = (state == S_PEND);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: exception > redirect > sequential, with stall-safe pending redirect.
// Optional build macro PC_TRACE_EN prints each PC change and its cause (simulation only).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = PC_EXC_VEC,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pending,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VEC) & ALIGN_MASK;
  localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VEC) & ALIGN_MASK;

  logic [WIDTH-1:0] target_al;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_redir;

  assign target_al = redir_target & ALIGN_MASK;
  assign pc_plus4  = pc + WIDTH'(PC_STEP);

  pc_pend_reg #(
    .WIDTH (WIDTH)
  ) u_pend (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .exc_req      (exc_req),
    .redir_valid  (redir_valid),
    .redir_target (target_al),
    .pend_target  (pend_target),
    .pending      (pending)
  );

  // Next-PC priority mux; an X on stall must reach pc rather than pick a branch.
  always_comb begin
    pc_nxt     = pc;
    load_redir = 1'b0;
    cnt_nxt    = redir_cnt;
    pc_nxt     = exc_req     ? EXC_PC
               : stall       ? pc
               : redir_valid ? target_al
               : pending     ? pend_target
               :               pc_plus4;
    load_redir = exc_req | (~stall & (redir_valid | pending));
    cnt_nxt    = (load_redir & ~(&redir_cnt)) ? redir_cnt + CNT_W'(1) : redir_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RST_PC;
      redir_cnt <= '0;
    end else begin
      pc        <= pc_nxt;
      redir_cnt <= cnt_nxt;
    end
  end

`ifdef PC_TRACE_EN
  always @(posedge clk) begin
    if (rst && (pc_nxt != pc)) begin
      $display("PC: 0x%08X cause=%s", pc_nxt,
               exc_req                 ? "EXC"
             : (!stall && redir_valid) ? "BR"
             : (!stall && pending)     ? "PEND"
             :                           "SEQ");
    end
  end
`else
`endif

endmodule
